// File: rtl/decoder_seq_pkg.sv
// Shared types and the one-hot helper for the decoder_seq block.
package decoder_seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  // Widest decode the helper supports (SEL_W up to 8).
  localparam int ONEHOT_MAX = 256;

  // One-hot of idx, or all-zero when idx is not below num_out.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input int idx, input int num_out);
    logic [ONEHOT_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < ONEHOT_MAX; i++) r[i] = (i == idx) && (i < num_out);
    return r;
  endfunction

endpackage

// File: rtl/decoder_seq_dwell.sv
// Dwell timer for sweep mode: latches the dwell length and counts up to it.
module decoder_seq_dwell #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               restart,
  input  logic               advance,
  input  logic [DWELL_W-1:0] dwell,
  output logic               term
);

  logic [DWELL_W-1:0] dwell_r;
  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_r <= '0;
      cnt     <= '0;
    end else if (load) begin
      dwell_r <= dwell;
      cnt     <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = (cnt == dwell_r);

endmodule

// File: rtl/decoder_seq.sv
// Registered SEL_W:NUM_OUT one-hot decoder with direct and sweep modes.
// Optional sticky range-error flag: define DECODER_SEQ_RANGE_ERR_EN.
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NUM_OUT-1:0] y,
  output logic               y_valid,
  output logic               err
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_OUT - 1);

  state_e             state, state_n;
  logic [SEL_W-1:0]   idx, idx_n;
  logic [NUM_OUT-1:0] y_n;
  logic               yv_n;
  logic               load, restart, advance, term;
  logic               in_range;

  assign in_ready = (state == ST_IDLE) && en;
  assign in_range = int'(sel) < NUM_OUT;

  decoder_seq_dwell #(.DWELL_W(DWELL_W)) u_dwell (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .restart (restart),
    .advance (advance),
    .dwell   (dwell),
    .term    (term)
  );

  // en low leaves every default in place: registers hold and y_valid drops.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    y_n     = y;
    yv_n    = 1'b0;
    load    = 1'b0;
    restart = 1'b0;
    advance = 1'b0;
    if (en) begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            yv_n = 1'b1;
            if (!mode) begin
              y_n = NUM_OUT'(onehot(int'(sel), NUM_OUT));
            end else begin
              idx_n   = in_range ? sel : '0;
              y_n     = NUM_OUT'(onehot(int'(idx_n), NUM_OUT));
              load    = 1'b1;
              state_n = ST_SWEEP;
            end
          end
        end
        ST_SWEEP: begin
          if (term) begin
            restart = 1'b1;
            if (mode) begin
              idx_n = (idx == LAST) ? '0 : idx + 1'b1;
              y_n   = NUM_OUT'(onehot(int'(idx_n), NUM_OUT));
              yv_n  = 1'b1;
            end else begin
              y_n     = '0;
              state_n = ST_IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      y       <= y_n;
      y_valid <= yv_n;
    end
  end

`ifdef DECODER_SEQ_RANGE_ERR_EN
  logic err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_r <= 1'b0;
    else if (in_valid && in_ready && !in_range) err_r <= 1'b1;
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: 8-line instance plus a 6-line instance for range cases.
module tb_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, in_valid, v6;
  logic [2:0] sel;
  logic [7:0] dwell;
  logic       in_ready, y_valid, err;
  logic [7:0] y;
  logic       rdy6, yv6, err6;
  logic [5:0] y6;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] sb[$];

`ifdef DECODER_SEQ_RANGE_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  decoder_seq #(.SEL_W(3), .NUM_OUT(8), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .dwell(dwell), .y(y), .y_valid(y_valid), .err(err)
  );

  decoder_seq #(.SEL_W(3), .NUM_OUT(6), .DWELL_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(v6),
    .in_ready(rdy6), .sel(sel), .dwell(dwell), .y(y6), .y_valid(yv6), .err(err6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every decoded update on the 8-line instance must match the next queued value.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot8", 32'($onehot0(y)), 32'd1);
      chk("onehot6", 32'($onehot0(y6)), 32'd1);
      if (y_valid) begin
        if (sb.size() == 0) chk("sb_unexpected", 32'(y), 32'hFFFF_FFFF);
        else chk("sb_y", 32'(y), sb.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; in_valid = 1'b0; v6 = 1'b0;
    sel = '0; dwell = '0;

    // Reset
    tick(3);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_yv", 32'(y_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_ready6", 32'(rdy6), 32'h1);

    // Direct decode
    sel = 3'd6; mode = 1'b0; in_valid = 1'b1; sb.push_back(32'h40);
    tick();
    in_valid = 1'b0;
    chk("dir_y", 32'(y), 32'h40);
    chk("dir_yv", 32'(y_valid), 32'h1);
    tick();
    chk("dir_yv_pulse", 32'(y_valid), 32'h0);
    chk("dir_hold", 32'(y), 32'h40);
    sel = 3'd1; in_valid = 1'b1; sb.push_back(32'h02);
    tick();
    in_valid = 1'b0;
    chk("dir_y2", 32'(y), 32'h02);
    tick();

    // Out-of-range on the 6-line instance
    sel = 3'd7; mode = 1'b0; v6 = 1'b1;
    tick();
    v6 = 1'b0;
    chk("rng_y", 32'(y6), 32'h0);
    chk("rng_yv", 32'(yv6), 32'h1);
    chk("rng_err", 32'(err6), 32'(EXP_ERR));
    chk("rng_err8", 32'(err), 32'h0);
    tick();
    chk("rng_err_sticky", 32'(err6), 32'(EXP_ERR));
    chk("rng_yv_pulse", 32'(yv6), 32'h0);

    // Sweep start out of range restarts at line 0; dwell 0 steps every cycle
    sel = 3'd7; mode = 1'b1; dwell = 8'd0; v6 = 1'b1;
    tick();
    v6 = 1'b0;
    chk("sw6_start", 32'(y6), 32'h01);
    chk("sw6_rdy", 32'(rdy6), 32'h0);
    tick();
    chk("sw6_step", 32'(y6), 32'h02);
    chk("sw6_yv", 32'(yv6), 32'h1);
    mode = 1'b0;
    tick();
    chk("sw6_exit_y", 32'(y6), 32'h0);
    chk("sw6_exit_rdy", 32'(rdy6), 32'h1);
    sel = 3'd5; mode = 1'b1; v6 = 1'b1;
    tick();
    v6 = 1'b0;
    chk("sw6_last", 32'(y6), 32'h20);
    tick();
    chk("sw6_wrap", 32'(y6), 32'h01);
    mode = 1'b0;
    tick();
    chk("sw6_exit2", 32'(y6), 32'h0);

    // Sweep on the 8-line instance with wrap
    sel = 3'd5; dwell = 8'd2; mode = 1'b1; in_valid = 1'b1;
    sb.push_back(32'h20); sb.push_back(32'h40); sb.push_back(32'h80); sb.push_back(32'h01);
    tick();
    in_valid = 1'b0;
    chk("swp_start", 32'(y), 32'h20);
    chk("swp_rdy0", 32'(in_ready), 32'h0);
    for (int c = 1; c <= 9; c++) begin
      logic [31:0] e;
      tick();
      e = (c < 3) ? 32'h20 : (c < 6) ? 32'h40 : (c < 9) ? 32'h80 : 32'h01;
      chk("swp_y", 32'(y), e);
      chk("swp_rdy", 32'(in_ready), 32'h0);
    end

    // Pause mid-dwell
    tick();
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("pause_y", 32'(y), 32'h01);
      chk("pause_yv", 32'(y_valid), 32'h0);
      chk("pause_rdy", 32'(in_ready), 32'h0);
    end
    en = 1'b1;
    sb.push_back(32'h02);
    tick();
    chk("pause_resume", 32'(y), 32'h01);
    tick();
    chk("pause_step", 32'(y), 32'h02);
    chk("pause_step_yv", 32'(y_valid), 32'h1);

    // Exit at dwell end
    mode = 1'b0;
    tick(2);
    chk("exit_hold", 32'(y), 32'h02);
    chk("exit_rdy0", 32'(in_ready), 32'h0);
    tick();
    chk("exit_y", 32'(y), 32'h0);
    chk("exit_yv", 32'(y_valid), 32'h0);
    chk("exit_rdy", 32'(in_ready), 32'h1);

    // Asynchronous reset mid-sweep
    sel = 3'd3; dwell = 8'd3; mode = 1'b1; in_valid = 1'b1; sb.push_back(32'h08);
    tick();
    in_valid = 1'b0;
    chk("rsw_y", 32'(y), 32'h08);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rsw_async_y", 32'(y), 32'h0);
    chk("rsw_async_yv", 32'(y_valid), 32'h0);
    chk("rsw_err6", 32'(err6), 32'h0);
    chk("rsw_idle", 32'(in_ready), 32'h1);
    tick();
    rst_n = 1'b1;
    tick(5);
    chk("rsw_after_y", 32'(y), 32'h0);
    chk("rsw_after_rdy", 32'(in_ready), 32'h1);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
